// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer for an external pipelined 8x8 multiplier.
// A tag pipe tracks which multiplier output cycles carry a real product.
module mac_seq_ctrl #(
  parameter int DATA_W   = 8,
  parameter int MAX_LEN  = 8,
  parameter int LEN_W    = $clog2(MAX_LEN+1),
  parameter int MULT_LAT = 2,
  parameter int ACC_W    = 2*DATA_W + $clog2(MAX_LEN)
) (
  input  logic                I_sys_clk,
  input  logic                I_sys_rst,
  input  logic                I_start,
  input  logic [LEN_W-1:0]    I_len,
  input  logic                I_abort,
  input  logic                I_op_valid,
  input  logic [DATA_W-1:0]   I_op_a,
  input  logic [DATA_W-1:0]   I_op_b,
  output logic                O_op_ready,
  output logic                O_mult_ena,
  output logic [DATA_W-1:0]   O_mult_a,
  output logic [DATA_W-1:0]   O_mult_b,
  input  logic [2*DATA_W-1:0] I_mult_p,
  output logic                O_busy,
  output logic [ACC_W-1:0]    O_result,
  output logic                O_result_valid
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   n_len, issued, retired, len_clamp;
  logic [MULT_LAT:0]  tag_pipe;
  logic [ACC_W-1:0]   acc, acc_sum;
  logic               accept, retire, last_issue, last_retire, start_take;

  assign len_clamp  = (I_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : I_len;
  assign start_take = (state == S_IDLE) && I_start;

  assign O_busy         = (state != S_IDLE);
  assign O_mult_ena     = (state == S_RUN) || (state == S_DRAIN);
  assign O_op_ready     = (state == S_RUN) && (issued < n_len);
  assign O_result_valid = (state == S_DONE);

  // Abort suppresses both accept and retire in the same cycle.
  assign accept      = O_op_ready & I_op_valid & ~I_abort;
  assign retire      = O_mult_ena & tag_pipe[MULT_LAT] & ~I_abort;
  assign last_issue  = accept && ((issued + LEN_W'(1)) == n_len);
  assign last_retire = retire && ((retired + LEN_W'(1)) == n_len);
  assign acc_sum     = acc + ACC_W'(I_mult_p);

  always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
    if (I_sys_rst) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (I_start) state_nxt = (len_clamp == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (I_abort)          state_nxt = S_IDLE;
        else if (last_retire) state_nxt = S_DONE;
        else if (last_issue)  state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (I_abort)          state_nxt = S_IDLE;
        else if (last_retire) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
    if (I_sys_rst) begin
      n_len    <= '0;
      issued   <= '0;
      retired  <= '0;
      tag_pipe <= '0;
      acc      <= '0;
      O_mult_a <= '0;
      O_mult_b <= '0;
      O_result <= '0;
    end else if (start_take) begin
      n_len    <= len_clamp;
      issued   <= '0;
      retired  <= '0;
      tag_pipe <= '0;
      acc      <= '0;
      if (len_clamp == '0) O_result <= '0;
    end else if (I_abort && (state != S_IDLE)) begin
      // O_result deliberately keeps the last completed job's value.
      issued   <= '0;
      retired  <= '0;
      tag_pipe <= '0;
      acc      <= '0;
    end else if (O_mult_ena) begin
      tag_pipe <= {tag_pipe[MULT_LAT-1:0], accept};
      if (accept) begin
        O_mult_a <= I_op_a;
        O_mult_b <= I_op_b;
        issued   <= issued + LEN_W'(1);
      end
      if (retire) begin
        acc     <= acc_sum;
        retired <= retired + LEN_W'(1);
        if (last_retire) O_result <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench: pipelined multiplier model plus a job-level reference
// (sum of accepted products, completion edge = N + stalls + MULT_LAT + 1).
module tb_mac_seq_ctrl;
  localparam int DATA_W   = 8;
  localparam int MAX_LEN  = 8;
  localparam int LEN_W    = 4;
  localparam int MULT_LAT = 2;
  localparam int ACC_W    = 19;

  logic              clk, rst, start, abort, op_valid;
  logic [LEN_W-1:0]  len_in;
  logic [7:0]        op_a, op_b, mult_a, mult_b;
  logic [15:0]       mult_p;
  logic              op_ready, mult_ena, busy, res_valid;
  logic [ACC_W-1:0]  result;

  int n_tests = 0;
  int n_fail  = 0;
  int pa[8];
  int pb[8];

  mac_seq_ctrl #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W),
                 .MULT_LAT(MULT_LAT), .ACC_W(ACC_W)) dut (
    .I_sys_clk(clk), .I_sys_rst(rst), .I_start(start), .I_len(len_in),
    .I_abort(abort), .I_op_valid(op_valid), .I_op_a(op_a), .I_op_b(op_b),
    .O_op_ready(op_ready), .O_mult_ena(mult_ena), .O_mult_a(mult_a),
    .O_mult_b(mult_b), .I_mult_p(mult_p), .O_busy(busy),
    .O_result(result), .O_result_valid(res_valid)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // External multiplier: MULT_LAT clock-enabled stages.
  logic [15:0] p_pipe [MULT_LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MULT_LAT; i++) p_pipe[i] <= '0;
    end else if (mult_ena) begin
      p_pipe[0] <= 16'(mult_a) * 16'(mult_b);
      for (int i = 1; i < MULT_LAT; i++) p_pipe[i] <= p_pipe[i-1];
    end
  end
  assign mult_p = p_pipe[MULT_LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: operands from pa/pb, 1: random operands and stalls, 2: all 255
  task automatic run_job(input string tag, input int len, input int mode,
                         input int gap_after, input int gap_len, input bit poke_start);
    int n_eff, e, acc_cnt, stalls, done_e, gap_used;
    logic [31:0] exp_sum;
    logic [7:0] la, a, b;
    bit done, v;
    n_eff = (len > MAX_LEN) ? MAX_LEN : len;
    e = 0; acc_cnt = 0; stalls = 0; done_e = 0; gap_used = 0;
    exp_sum = 0; la = 0; done = 0;
    @(negedge clk);
    start = 1; len_in = LEN_W'(len);
    @(posedge clk);
    while (!done && e < 200) begin
      @(negedge clk);
      start = 0; op_valid = 0;
      if (res_valid) begin
        done = 1; done_e = e;
        chk({tag, "/busy_done"}, busy, 1);
      end else begin
        if (acc_cnt > 0) chk({tag, "/mult_a_hold"}, mult_a, la);
        if (poke_start && e == 2) begin start = 1; len_in = 1; end
        if (op_ready) begin
          if (mode == 1) v = ($urandom_range(0, 3) != 0);
          else if (acc_cnt == gap_after && gap_used < gap_len) begin v = 0; gap_used++; end
          else v = 1;
          case (mode)
            0:       begin a = 8'(pa[acc_cnt]); b = 8'(pb[acc_cnt]); end
            1:       begin a = 8'($urandom); b = 8'($urandom); end
            default: begin a = 8'd255; b = 8'd255; end
          endcase
          op_valid = v; op_a = a; op_b = b;
          if (v) begin
            acc_cnt++; exp_sum += 32'(a) * 32'(b); la = a;
          end else stalls++;
        end else if (mode == 1) begin
          op_valid = 1'($urandom_range(0, 1));
          op_a = 8'($urandom); op_b = 8'($urandom);
        end
      end
      if (!done) begin @(posedge clk); e++; end
    end
    op_valid = 0;
    if (!done) chk({tag, "/timeout"}, 0, 1);
    else begin
      chk({tag, "/accepted"}, acc_cnt, n_eff);
      chk({tag, "/result"}, result, exp_sum);
      chk({tag, "/latency"}, done_e, (n_eff == 0) ? 0 : n_eff + stalls + MULT_LAT + 1);
      @(negedge clk);
      chk({tag, "/valid_pulse"}, res_valid, 0);
      chk({tag, "/busy_after"}, busy, 0);
    end
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; op_valid = 0; len_in = 0; op_a = 0; op_b = 0;
    #3;
    chk("reset_outs", {busy, op_ready, mult_ena, res_valid, mult_a, mult_b}, 0);
    chk("reset_result", result, 0);
    @(negedge clk); rst = 0;

    pa = '{1, 3, 5, 7, 0, 0, 0, 0};
    pb = '{2, 4, 6, 8, 0, 0, 0, 0};
    run_job("n4", 4, 0, 0, 0, 0);
    chk("n4/value", result, 100);
    run_job("n4_gap", 4, 0, 2, 3, 0);
    run_job("n8_max", 8, 2, 0, 0, 0);
    chk("n8/value", result, 520200);
    run_job("n12_clamp", 12, 2, 0, 0, 0);
    run_job("n0", 0, 0, 0, 0, 0);
    chk("n0/value", result, 0);
    run_job("n4_poke", 4, 0, 0, 0, 1);
    chk("poke/value", result, 100);

    // Abort during DRAIN: no pulse, prior result kept.
    @(negedge clk); start = 1; len_in = 4;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); start = 0; op_valid = 1; op_a = 8'(pa[k]); op_b = 8'(pb[k]);
      @(posedge clk);
    end
    @(negedge clk); op_valid = 0; abort = 1;
    chk("abort/in_drain", {busy, op_ready, mult_ena}, 3'b101);
    @(posedge clk);
    @(negedge clk); abort = 0;
    chk("abort/idle", {busy, mult_ena}, 0);
    for (int k = 0; k < 6; k++) begin
      chk("abort/no_valid", res_valid, 0);
      chk("abort/result_kept", result, 100);
      @(negedge clk);
    end
    pa[0] = 9; pb[0] = 9;
    run_job("after_abort", 1, 0, 0, 0, 0);
    chk("after_abort/value", result, 81);

    // Asynchronous reset mid-RUN.
    @(negedge clk); start = 1; len_in = 4;
    @(posedge clk);
    @(negedge clk); start = 0; op_valid = 1; op_a = 8'd10; op_b = 8'd10;
    @(posedge clk);
    @(negedge clk); #2 rst = 1;
    #1;
    chk("rst_mid/outs", {busy, op_ready, mult_ena, res_valid, mult_a, mult_b}, 0);
    chk("rst_mid/result", result, 0);
    @(negedge clk); rst = 0; op_valid = 0;
    pa = '{2, 4, 0, 0, 0, 0, 0, 0};
    pb = '{3, 5, 0, 0, 0, 0, 0, 0};
    run_job("post_rst", 2, 0, 0, 0, 0);
    chk("post_rst/value", result, 26);

    for (int j = 0; j < 10; j++) run_job("rand", $urandom_range(0, 12), 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer for the 8x8 pipelined multiply-accumulate path used by the matrix-inverse datapath. It accepts a dot-product job of length N, pulls N operand pairs over a valid/ready stream and drives them into the external pipelined multiplier. It tags each in-flight product, accumulates products as they emerge, and returns one result with a single-cycle valid pulse. It replaces fixed free-running cycle windows with explicit job control.

Parameters:
DATA_W, 8, operand width (unsigned)
MAX_LEN, 8, maximum dot-product length
LEN_W, $clog2(MAX_LEN+1) = 4, width of length field
MULT_LAT, 2, multiplier latency in enabled cycles from A/B to P (>=1)
ACC_W, 2*DATA_W+$clog2(MAX_LEN) = 19, accumulator/result width

Ports:
I_sys_clk  in  1  system clock, all logic on rising edge
I_sys_rst  in  1  reset, asynchronous, active-high
I_start  in  1  job start request, sampled in IDLE only
I_len  in  LEN_W  job length N, captured with I_start
I_abort  in  1  synchronous job cancel
I_op_valid  in  1  operand pair valid
I_op_a  in  DATA_W  operand A
I_op_b  in  DATA_W  operand B
O_op_ready  out  1  controller accepts operand pair this cycle
O_mult_ena  out  1  multiplier clock enable (CE)
O_mult_a  out  DATA_W  registered multiplier input A
O_mult_b  out  DATA_W  registered multiplier input B
I_mult_p  in  2*DATA_W  multiplier product
O_busy  out  1  job in progress
O_result  out  ACC_W  dot-product result, held until next job completes
O_result_valid  out  1  one-cycle pulse, O_result new

Behaviour:
- Reset, async, active-high: state IDLE; all outputs 0; accumulator, counters and tag pipe cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: O_busy=0, O_op_ready=0, O_mult_ena=0. I_start=1: capture N=min(I_len,MAX_LEN), clear accumulator, issue/retire counters=0, go RUN (N=0: go DONE directly). I_start in any other state ignored.
- RUN: O_busy=1, O_mult_ena=1, O_op_ready=1 while issued<N. Accept on I_op_valid&O_op_ready: O_mult_a/b <= I_op_a/b, tag bit 1 enters tag pipe (depth MULT_LAT+1), issued++. Non-accept cycle: tag 0 enters, O_mult_a/b hold. When issued reaches N (same edge as last accept), go DRAIN.
- DRAIN: O_op_ready=0, O_mult_ena=1, zero tags shift in.
- Retire (RUN or DRAIN): tag at pipe output =1 -> acc <= acc + zero-extended I_mult_p, retired++. Retire of Nth product: O_result <= acc+I_mult_p, O_result_valid <= 1, go DONE.
- DONE: one cycle; O_result_valid=1, O_busy=1; next edge -> IDLE, valid drops. N=0 job: O_result=0.
- Timing, no stalls, start sampled at edge 0: operand k accepted at edge k (1..N); product k accumulated at edge k+MULT_LAT+1; O_result_valid high in the cycle after edge N+MULT_LAT+1. Each stall cycle delays completion by one.
- Width: unsigned; ACC_W guarantees no overflow for N<=MAX_LEN, full-scale operands; no saturation.
- I_abort (RUN/DRAIN/DONE): next edge -> IDLE, tags cleared, accumulator cleared, no O_result_valid, O_result retains previous value. I_abort in IDLE: no effect. I_abort wins over retire/accept the same cycle.
- I_start together with I_abort in IDLE: start taken.
- Reset mid-job: immediate return to reset state, no result.
- O_mult_ena=1 in RUN/DRAIN so the multiplier pipeline and tag pipe stay aligned; 0 in IDLE/DONE.

Test Plan:
- Bench multiplier model MULT_LAT=2; N=4, pairs (1,2),(3,4),(5,6),(7,8), op_valid continuous -> O_result=100, valid exactly one cycle, after edge 7 (N+MULT_LAT+1), O_busy low next cycle.
- Same job with op_valid low 3 cycles between pairs 2 and 3 -> O_result=100, valid delayed exactly 3 cycles; O_mult_a/b hold during gaps.
- N=8, all operands 255 -> O_result=520200 (0x7F008), no truncation; I_len=12 -> clamped, only 8 pairs accepted (O_op_ready low after 8th).
- N=0 -> O_result=0, O_result_valid in cycle after start edge, no O_op_ready; I_start pulsed during RUN -> ignored, running result unchanged.
- I_abort during DRAIN of N=4 job -> IDLE next cycle, no valid pulse, O_result keeps prior 100; follow-up N=1 job (9,9) -> 81.
- I_sys_rst asserted asynchronously mid-RUN -> all outputs 0 immediately; after release a fresh N=2 job (2,3),(4,5) -> 26.
